// File: rtl/reset_seq_pkg.sv
// Shared definitions for the power-on / warm reset sequencer: state encoding,
// timedelay tap indices and the default tap-wait timeout.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    StOff,
    StRamp,
    StClkOn,
    StPeriph,
    StCpu,
    StRun,
    StDrain,
    StFault
  } seq_state_e;

  // Bit positions within td_t = {t125, t100, t75, t50, t25, t5}
  localparam int unsigned T5   = 0;
  localparam int unsigned T25  = 1;
  localparam int unsigned T50  = 2;
  localparam int unsigned T75  = 3;
  localparam int unsigned T100 = 4;
  localparam int unsigned T125 = 5;

  localparam int unsigned NumTaps        = 6;
  localparam int unsigned DefaultTimeout = 64;

endpackage

// File: rtl/reset_sequencer.sv
// Reset sequencer driving an external tapped timedelay: ramps clock enable, peripheral
// and CPU resets off in order on tap edges, with warm reset, brown-out and timeout fault.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwr_good,
  input  logic               sw_reset_req,
  input  logic [NumTaps-1:0] td_t,
  output logic               td_in,
  output logic               clk_en,
  output logic               periph_reset,
  output logic               cpu_reset,
  output logic               ready,
  output logic               fault,
  output logic [7:0]         seq_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Fault fires on the edge where the counter would otherwise reach TIMEOUT
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  seq_state_e      state;
  logic [CntW-1:0] wait_cnt;
  logic            advance;

  // Tap condition that releases the current wait state
  always_comb begin
    advance = 1'b0;
    case (state)
      StRamp:   advance = td_t[T25];
      StClkOn:  advance = td_t[T50];
      StPeriph: advance = td_t[T100];
      StCpu:    advance = td_t[T125];
      StDrain:  advance = (td_t == '0);
      default:  advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StOff;
      td_in        <= 1'b0;
      clk_en       <= 1'b0;
      periph_reset <= 1'b1;
      cpu_reset    <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      seq_count    <= 8'd0;
      wait_cnt     <= '0;
    end else if (!pwr_good) begin
      // Brown-out wins over everything, and is also the only exit from FAULT
      state        <= StOff;
      td_in        <= 1'b0;
      clk_en       <= 1'b0;
      periph_reset <= 1'b1;
      cpu_reset    <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      unique case (state)
        StOff: begin
          if (td_t == '0) begin
            state    <= StRamp;
            td_in    <= 1'b1;
            wait_cnt <= '0;
          end
        end
        StRamp, StClkOn, StPeriph, StCpu, StDrain: begin
          if (advance) begin
            wait_cnt <= '0;
            case (state)
              StRamp: begin
                state  <= StClkOn;
                clk_en <= 1'b1;
              end
              StClkOn: begin
                state        <= StPeriph;
                periph_reset <= 1'b0;
              end
              StPeriph: begin
                state     <= StCpu;
                cpu_reset <= 1'b0;
              end
              StCpu: begin
                state <= StRun;
                ready <= 1'b1;
                td_in <= 1'b0;
                if (seq_count != 8'hff) seq_count <= seq_count + 8'd1;
              end
              StDrain: begin
                state <= StRamp;
                td_in <= 1'b1;
              end
              default: ;
            endcase
          end else if (wait_cnt == CntLast) begin
            state        <= StFault;
            fault        <= 1'b1;
            td_in        <= 1'b0;
            clk_en       <= 1'b0;
            periph_reset <= 1'b1;
            cpu_reset    <= 1'b1;
            ready        <= 1'b0;
            wait_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + CntW'(1);
          end
        end
        StRun: begin
          // clk_en is left running through the warm reset
          if (sw_reset_req) begin
            state        <= StDrain;
            cpu_reset    <= 1'b1;
            periph_reset <= 1'b1;
            ready        <= 1'b0;
            td_in        <= 1'b0;
            wait_cnt     <= '0;
          end
        end
        StFault: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: direct-drive vector table, then scenario runs against a
// shift-register model of the timedelay.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwr_good = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [5:0] td_t;
  logic [5:0] td_force = 6'd0;
  logic       use_model = 1'b0;
  logic       td_in, clk_en, periph_reset, cpu_reset, ready, fault;
  logic [7:0] seq_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Timedelay model: t5 one edge after td_in, t25 at 5, t50 at 10, t75 at 15, ...
  logic [24:0] sh = '0;
  logic [5:0]  model_taps;
  always @(posedge clk) sh <= {sh[23:0], td_in};
  assign model_taps = {sh[24], sh[19], sh[14], sh[9], sh[4], sh[0]};
  assign td_t = use_model ? model_taps : td_force;

  reset_sequencer #(.TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwr_good     (pwr_good),
    .sw_reset_req (sw_reset_req),
    .td_t         (td_t),
    .td_in        (td_in),
    .clk_en       (clk_en),
    .periph_reset (periph_reset),
    .cpu_reset    (cpu_reset),
    .ready        (ready),
    .fault        (fault),
    .seq_count    (seq_count)
  );

  // {td_in, clk_en, periph_reset, cpu_reset, ready, fault}
  logic [5:0] obs;
  assign obs = {td_in, clk_en, periph_reset, cpu_reset, ready, fault};

  localparam logic [5:0] OffV   = 6'b001100;
  localparam logic [5:0] RampV  = 6'b101100;
  localparam logic [5:0] ClkV   = 6'b111100;
  localparam logic [5:0] PerV   = 6'b110100;
  localparam logic [5:0] CpuV   = 6'b110000;
  localparam logic [5:0] RunV   = 6'b010010;
  localparam logic [5:0] DrainV = 6'b011100;
  localparam logic [5:0] FaultV = 6'b001101;

  typedef struct {
    logic       pg;
    logic       sw;
    logic [5:0] td;
    logic [5:0] flags;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic pg, input logic sw, input logic [5:0] td,
                              input logic [5:0] flags, input logic [7:0] cnt);
    vec_t v;
    v.pg = pg; v.sw = sw; v.td = td; v.flags = flags; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t_td, t_ck, t_pr, t_cpu, t_rdy;
    int clk_drops, rearm_k;
    logic got, pre_zero;

    vecs[0]  = mk(0, 0, 6'b000000, OffV,   8'd0);
    vecs[1]  = mk(1, 0, 6'b000001, OffV,   8'd0);
    vecs[2]  = mk(1, 0, 6'b000000, RampV,  8'd0);
    vecs[3]  = mk(1, 0, 6'b000001, RampV,  8'd0);
    vecs[4]  = mk(1, 1, 6'b000001, RampV,  8'd0);
    vecs[5]  = mk(1, 0, 6'b000011, ClkV,   8'd0);
    vecs[6]  = mk(1, 0, 6'b000011, ClkV,   8'd0);
    vecs[7]  = mk(1, 0, 6'b000111, PerV,   8'd0);
    vecs[8]  = mk(1, 0, 6'b001111, PerV,   8'd0);
    vecs[9]  = mk(1, 0, 6'b011111, CpuV,   8'd0);
    vecs[10] = mk(1, 1, 6'b011111, CpuV,   8'd0);
    vecs[11] = mk(1, 0, 6'b111111, RunV,   8'd1);
    vecs[12] = mk(1, 0, 6'b111111, RunV,   8'd1);
    vecs[13] = mk(1, 1, 6'b111111, DrainV, 8'd1);
    vecs[14] = mk(1, 0, 6'b111110, DrainV, 8'd1);
    vecs[15] = mk(1, 0, 6'b000000, ClkV,   8'd1);  // back in RAMP, clk_en still on
    vecs[16] = mk(1, 0, 6'b000011, ClkV,   8'd1);
    vecs[17] = mk(1, 0, 6'b000111, PerV,   8'd1);
    vecs[18] = mk(0, 0, 6'b000111, OffV,   8'd1);
    vecs[19] = mk(1, 0, 6'b000111, OffV,   8'd1);
    vecs[20] = mk(1, 0, 6'b000000, RampV,  8'd1);
    vecs[21] = mk(1, 0, 6'b000011, ClkV,   8'd1);
    vecs[22] = mk(1, 0, 6'b000111, PerV,   8'd1);
    vecs[23] = mk(1, 0, 6'b011111, CpuV,   8'd1);
    vecs[24] = mk(1, 0, 6'b111111, RunV,   8'd2);
    vecs[25] = mk(0, 0, 6'b111111, OffV,   8'd2);

    // Reset state
    #12;
    check("reset_outputs", 32'(obs), 32'(OffV));
    check("reset_seq_count", 32'(seq_count), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      pwr_good = vecs[i].pg;
      sw_reset_req = vecs[i].sw;
      td_force = vecs[i].td;
      step();
      check($sformatf("vec%0d", i), 32'({obs, seq_count}), 32'({vecs[i].flags, vecs[i].cnt}));
    end
    sw_reset_req = 1'b0;

    // Cold start with timedelay model, ignored request during CLKON
    use_model = 1'b1;
    pwr_good = 1'b0;
    repeat (30) step();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    pwr_good = 1'b1;
    t_td = -1; t_ck = -1; t_pr = -1; t_cpu = -1; t_rdy = -1;
    for (int k = 0; k <= 30; k++) begin
      if (k == 9) sw_reset_req = 1'b1;
      step();
      sw_reset_req = 1'b0;
      if (k == 9) check("ignored_req_clkon", 32'(obs), 32'(ClkV));
      if (td_in && t_td < 0) t_td = k;
      if (clk_en && t_ck < 0) t_ck = k;
      if (!periph_reset && t_pr < 0) t_pr = k;
      if (!cpu_reset && t_cpu < 0) t_cpu = k;
      if (ready && t_rdy < 0) t_rdy = k;
    end
    check("cold_td_in_edge", 32'(t_td), 32'd0);
    check("cold_clk_en_edge", 32'(t_ck), 32'd6);
    check("cold_periph_edge", 32'(t_pr), 32'd11);
    check("cold_cpu_edge", 32'(t_cpu), 32'd21);
    check("cold_ready_edge", 32'(t_rdy), 32'd26);
    check("cold_seq_count", 32'(seq_count), 32'd1);

    // Warm reset from RUN
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    check("warm_entry", 32'(obs), 32'(DrainV));
    got = 1'b0;
    clk_drops = 0;
    for (int k = 0; k < 120 && !got; k++) begin
      step();
      if (!clk_en) clk_drops++;
      if (ready) got = 1'b1;
    end
    check("warm_ready_reached", 32'(got), 32'd1);
    check("warm_clk_en_held", 32'(clk_drops), 32'd0);
    check("warm_seq_count", 32'(seq_count), 32'd2);

    // Brown-out in PERIPH
    pwr_good = 1'b0;
    step();
    check("run_brownout", 32'(obs), 32'(OffV));
    repeat (30) step();
    pwr_good = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (!periph_reset) got = 1'b1;
    end
    check("reach_periph", 32'(got), 32'd1);
    pwr_good = 1'b0;
    step();
    check("periph_brownout", 32'(obs), 32'(OffV));
    pwr_good = 1'b1;
    got = 1'b0;
    pre_zero = 1'b0;
    rearm_k = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      pre_zero = (td_t == 6'd0);
      step();
      if (td_in) begin
        got = 1'b1;
        rearm_k = k;
      end
    end
    check("brownout_rearm", 32'(got), 32'd1);
    check("rearm_taps_zero", 32'(pre_zero), 32'd1);
    check("rearm_waited_drain", 32'(rearm_k > 20), 32'd1);

    // Async reset while in CPU
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (!cpu_reset) got = 1'b1;
    end
    check("reach_cpu", 32'(got), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs), 32'(OffV));
    check("async_reset_count", 32'(seq_count), 32'd0);
    #2 rst = 1'b1;

    // Timeout in RAMP with taps stuck low
    use_model = 1'b0;
    td_force = 6'd0;
    step();
    check("timeout_ramp_entry", 32'(obs), 32'(RampV));
    repeat (63) step();
    check("timeout_not_yet", 32'(fault), 32'd0);
    step();
    check("timeout_fault", 32'(obs), 32'(FaultV));
    repeat (5) step();
    check("fault_sticky", 32'(obs), 32'(FaultV));
    pwr_good = 1'b0;
    step();
    check("fault_cleared", 32'(obs), 32'(OffV));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
